sum_accumulator: RTL and testbench

- Downstream consumer of the team's ripple-carry adder output.
- Takes a stream of (DATA_WIDTH+1)-bit sums over a valid/ready handshake and adds BEATS consecutive sums into a wide accumulator.
- Presents the burst total on a valid/ready output port, then clears and starts the next burst.
- Used wherever per-cycle adder results must be reduced (e.g. dot-product or checksum tails).

---
 rtl/sum_accumulator.sv | 131 +++++++++++++
 tb/tb_sum_accumulator.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// ---------------------------------------------------------------------------
// sum_accumulator
//
// Reduces a stream of unsigned adder results into burst totals. BEATS
// consecutive sums accepted on the input handshake are added into a wide
// accumulator. The total is then presented on the output handshake and held
// until it is taken, after which the next burst starts.
//
// Parameters
//   DATA_WIDTH : operand width of the upstream adder (din is DATA_WIDTH+1 bits)
//   BEATS      : sums per burst, >= 1
//   ACC_WIDTH  : accumulator / dout width, wide enough that a burst never wraps
//
// Ports
//   clk        : rising-edge clock
//   resetn     : asynchronous active-low reset
//   din        : unsigned sum from the adder
//   din_valid  : din is valid this cycle
//   din_ready  : block accepts din this cycle (collecting and no clr)
//   clr        : synchronous abort of a partial burst (ignored while holding)
//   dout       : burst total, unsigned; keeps its last value after hand-off
//   dout_valid : dout holds a completed total
//   dout_ready : consumer takes dout this cycle
//   beat_cnt   : sums accepted so far in the current burst
// ---------------------------------------------------------------------------
module sum_accumulator #(
   parameter int DATA_WIDTH = 8,
   parameter int BEATS      = 4,
   parameter int ACC_WIDTH  = DATA_WIDTH + 1 + ((BEATS > 1) ? $clog2(BEATS) : 1)
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic [DATA_WIDTH:0]          din,
   input  logic                         din_valid,
   output logic                         din_ready,
   input  logic                         clr,
   output logic [ACC_WIDTH-1:0]         dout,
   output logic                         dout_valid,
   input  logic                         dout_ready,
   output logic [$clog2(BEATS+1)-1:0]   beat_cnt
);

   localparam int CNT_W = $clog2(BEATS + 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic {
      ST_ACC  = 1'b0,   // collecting sums
      ST_HOLD = 1'b1    // presenting a completed total
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [ACC_WIDTH-1:0]  acc;
   logic [ACC_WIDTH-1:0]  acc_next;
   logic [ACC_WIDTH-1:0]  dout_next;
   logic                  dout_valid_next;
   logic [CNT_W-1:0]      beat_cnt_next;
   logic [ACC_WIDTH-1:0]  sum;
   logic                  in_hs;
   logic                  last_beat;

   // clr blocks acceptance so an aborted beat is never half-consumed.
   assign din_ready = (state == ST_ACC) && !clr;
   assign in_hs     = din_valid && din_ready;
   assign last_beat = (beat_cnt == LAST_BEAT);
   assign sum       = acc + ACC_WIDTH'(din);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_ACC;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         acc        <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         beat_cnt   <= '0;
      end else begin
         acc        <= acc_next;
         dout       <= dout_next;
         dout_valid <= dout_valid_next;
         beat_cnt   <= beat_cnt_next;
      end
   end

   // NOTE: every signal written here gets a hold default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_next      = state;
      acc_next        = acc;
      dout_next       = dout;
      dout_valid_next = dout_valid;
      beat_cnt_next   = beat_cnt;

      case (state)
         ST_ACC: begin
            if (clr) begin
               acc_next      = '0;
               beat_cnt_next = '0;
            end else if (in_hs) begin
               if (last_beat) begin
                  // Final beat goes straight into dout; the accumulator is
                  // already clear for the next burst.
                  dout_next       = sum;
                  dout_valid_next = 1'b1;
                  state_next      = ST_HOLD;
                  acc_next        = '0;
                  beat_cnt_next   = '0;
               end else begin
                  acc_next      = sum;
                  beat_cnt_next = beat_cnt + 1'b1;
               end
            end
         end
         ST_HOLD: begin
            // clr is deliberately ignored here: a finished total is never lost.
            if (dout_ready) begin
               dout_valid_next = 1'b0;
               state_next      = ST_ACC;
            end
         end
      endcase
   end

endmodule

// File: tb/tb_sum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_sum_accumulator
//
// Directed scenarios followed by a random phase. A queue-based reference
// model tracks accepted sums per burst and the pending total; every cycle the
// DUT outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_sum_accumulator;

   localparam int DATA_WIDTH = 8;
   localparam int BEATS      = 4;
   localparam int ACC_WIDTH  = 11;
   localparam int CNT_W      = 3;

   logic                   clk        = 1'b0;
   logic                   resetn     = 1'b0;
   logic [DATA_WIDTH:0]    din        = '0;
   logic                   din_valid  = 1'b0;
   logic                   din_ready;
   logic                   clr        = 1'b0;
   logic [ACC_WIDTH-1:0]   dout;
   logic                   dout_valid;
   logic                   dout_ready = 1'b0;
   logic [CNT_W-1:0]       beat_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: sums accepted in the open burst, whether a total is
   // pending, and the last total presented.
   int unsigned m_q[$];
   bit          m_hold;
   int unsigned m_dout;

   sum_accumulator #(
      .DATA_WIDTH (DATA_WIDTH),
      .BEATS      (BEATS),
      .ACC_WIDTH  (ACC_WIDTH)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .clr        (clr),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .beat_cnt   (beat_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_hold = 1'b0;
      m_dout = 0;
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_edge();
      int unsigned total;
      if (m_hold) begin
         if (dout_ready) m_hold = 1'b0;
      end else if (clr) begin
         m_q.delete();
      end else if (din_valid) begin
         m_q.push_back(int'(din));
         if (m_q.size() == BEATS) begin
            total = 0;
            foreach (m_q[i]) total += m_q[i];
            m_dout = total;
            m_hold = 1'b1;
            m_q.delete();
         end
      end
   endtask

   // One clock cycle: entered at posedge+1, leaves at the next posedge+1.
   task automatic cycle(input logic v, input logic [DATA_WIDTH:0] d,
                        input logic c, input logic r);
      din_valid  = v;
      din        = d;
      clr        = c;
      dout_ready = r;
      #1;
      check("din_ready", 32'(din_ready), 32'(!m_hold && !c));
      model_edge();
      @(posedge clk);
      #1;
      check("dout",       32'(dout),       m_dout);
      check("dout_valid", 32'(dout_valid), 32'(m_hold));
      check("beat_cnt",   32'(beat_cnt),   32'(m_q.size()));
   endtask

   initial begin
      model_reset();

      // Reset values while resetn is low.
      #3;
      check("reset_dout",       32'(dout),       32'd0);
      check("reset_dout_valid", 32'(dout_valid), 32'd0);
      check("reset_beat_cnt",   32'(beat_cnt),   32'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;

      // Basic burst: 10,20,30,40 -> 100, valid for exactly one cycle.
      cycle(1, 9'd10, 0, 1);
      check("basic_beat1", 32'(beat_cnt), 32'd1);
      cycle(1, 9'd20, 0, 1);
      cycle(1, 9'd30, 0, 1);
      cycle(1, 9'd40, 0, 1);
      check("basic_total", 32'(dout), 32'd100);
      check("basic_valid", 32'(dout_valid), 32'd1);
      cycle(0, 9'd0, 0, 1);
      check("basic_valid_drop", 32'(dout_valid), 32'd0);

      // Maximum operands: 4 x 510 -> 2040 with no truncation.
      repeat (4) cycle(1, 9'd510, 0, 1);
      check("max_total", 32'(dout), 32'd2040);
      cycle(0, 9'd0, 0, 1);

      // Backpressure: result held, input stalled, clr ignored while holding.
      cycle(1, 9'd1, 0, 0);
      cycle(1, 9'd2, 0, 0);
      cycle(1, 9'd3, 0, 0);
      cycle(1, 9'd4, 0, 0);
      for (int i = 0; i < 5; i++) cycle(1, 9'd9, (i == 2), 0);
      check("bp_total", 32'(dout), 32'd10);
      check("bp_valid", 32'(dout_valid), 32'd1);
      cycle(1, 9'd9, 0, 1);   // output handshake, bubble on input
      check("bp_release_cnt", 32'(beat_cnt), 32'd0);
      cycle(1, 9'd9, 0, 1);   // next burst starts here
      check("bp_restart_cnt", 32'(beat_cnt), 32'd1);
      cycle(0, 9'd0, 1, 1);   // abort the partial burst

      // Gapped input: 5,6,7,8 with idle cycles between -> 26.
      cycle(1, 9'd5, 0, 1);
      cycle(0, 9'd77, 0, 1);
      cycle(1, 9'd6, 0, 1);
      cycle(0, 9'd77, 0, 1);
      cycle(1, 9'd7, 0, 1);
      cycle(0, 9'd77, 0, 1);
      cycle(1, 9'd8, 0, 1);
      check("gap_total", 32'(dout), 32'd26);
      cycle(0, 9'd0, 0, 1);

      // clr abort: 100,100, then clr with a valid 50 that must not be taken.
      cycle(1, 9'd100, 0, 1);
      cycle(1, 9'd100, 0, 1);
      cycle(1, 9'd50, 1, 1);
      check("clr_cnt", 32'(beat_cnt), 32'd0);
      repeat (4) cycle(1, 9'd1, 0, 1);
      check("clr_total", 32'(dout), 32'd4);
      cycle(0, 9'd0, 0, 1);

      // Asynchronous reset while holding a result.
      repeat (4) cycle(1, 9'd25, 0, 0);
      check("hold_total", 32'(dout), 32'd100);
      #4;
      resetn = 1'b0;
      #1;
      model_reset();
      check("areset_dout",       32'(dout),       32'd0);
      check("areset_dout_valid", 32'(dout_valid), 32'd0);
      check("areset_beat_cnt",   32'(beat_cnt),   32'd0);
      @(posedge clk);
      #1;
      resetn     = 1'b1;
      din_valid  = 1'b0;
      clr        = 1'b0;
      #1;
      check("post_reset_ready", 32'(din_ready), 32'd1);
      check("post_reset_cnt",   32'(beat_cnt),  32'd0);
      @(posedge clk);
      #1;

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 3) != 0),
               9'($urandom_range(0, 510)),
               ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 2) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
